// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels, common to
// the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_buf.sv
// One-entry holding register between the valid/ready byte interface and the
// transmit shifter; emptied by a clear strobe when the shifter loads it.
module uart_tx_buf #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 clr_i,
  output logic                 full_o,
  output logic [DATA_BITS-1:0] data_o
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  // Clear and accept are mutually exclusive: clear needs full, accept needs empty.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter paced by the shared baud tick (enb).
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned          IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 buf_full, buf_clr, load;
  logic [DATA_BITS-1:0] buf_data;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_tx_buf #(.DATA_BITS(DATA_BITS)) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data_in),
    .valid_i (data_valid),
    .ready_o (data_ready),
    .clr_i   (buf_clr),
    .full_o  (buf_full),
    .data_o  (buf_data)
  );

  // done is decoded from the final stop tick itself so it coincides with the
  // end of the last stop bit instead of trailing it by a cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    buf_clr    = 1'b0;
    load       = 1'b0;
    tx         = UART_IDLE_LEVEL;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (buf_full && enb) load = 1'b1;
      end
      ST_START: begin
        tx = UART_START_LEVEL;
        if (enb) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (enb) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d    = ST_PARITY;
`else
            state_d    = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = parity_q;
        if (enb) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (enb) begin
          if (stop_cnt_q == STOP_LAST) begin
            done       = 1'b1;
            stop_cnt_d = 1'b0;
            if (buf_full) load = 1'b1;
            else          state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d = buf_data;
      buf_clr = 1'b1;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^buf_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels come from a frame
// model built from the byte value, plus a mid-bit sampling receiver model.
module tb_uart_tx;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enb = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_ready, tx, busy, done;
  logic          data_ready2, tx2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(DW), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  uart_tx #(.DATA_BITS(DW), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready2),
    .tx         (tx2),
    .busy       (busy2),
    .done       (done2)
  );

  function automatic int frame_len(input int sb);
`ifdef UART_TX_PARITY_EN
    return 2 + DW + sb;
`else
    return 1 + DW + sb;
`endif
  endfunction

  // Line level of bit position k within the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Inputs change 1 ns after posedge; outputs are sampled 1 ns later.
  task automatic tick(input logic e, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    enb = e;
    data_valid = v;
    data_in = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'($urandom), 1'b1, 8'($urandom));
    tick(1'b0, 1'b0, 8'h00);
    n_tests++;
    if ({tx, busy, done, data_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_state: tx/busy/done/ready=%b expected 1001", {tx, busy, done, data_ready});
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1'($urandom), 1'b0, 8'($urandom));
      n_tests++;
      if ({tx, busy, done, data_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL idle_enb cyc%0d: tx/busy/done/ready=%b expected 1001", i, {tx, busy, done, data_ready});
      end
    end
  endtask

  task automatic test_enb_high();
    int f;
    logic [7:0] b;
    f = frame_len(1);
    for (int n = 0; n < 6; n++) begin
      b = (n == 0) ? 8'hA5 : (n == 1) ? 8'h07 : 8'($urandom);
      tick(1'b0, 1'b1, b);
      tick(1'b1, 1'b0, 8'h00);
      n_tests++;
      if ({tx, busy, done, data_ready} !== 4'b1000) begin
        n_fail++;
        $display("FAIL fast_buffered b=%h: tx/busy/done/ready=%b expected 1000", b, {tx, busy, done, data_ready});
      end
      for (int k = 0; k < f; k++) begin
        tick(1'b1, 1'b0, 8'($urandom));
        n_tests++;
        if ({tx, busy, done, data_ready} !== {frame_bit(b, k), 1'b1, 1'(k == f - 1), 1'b1}) begin
          n_fail++;
          $display("FAIL fast_frame b=%h bit%0d: tx/busy/done/ready=%b expected %b",
                   b, k, {tx, busy, done, data_ready}, {frame_bit(b, k), 1'b1, 1'(k == f - 1), 1'b1});
        end
      end
      tick(1'b0, 1'b0, 8'h00);
      n_tests++;
      if ({tx, busy, done, data_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL fast_end b=%h: tx/busy/done/ready=%b expected 1001", b, {tx, busy, done, data_ready});
      end
    end
  endtask

  task automatic test_slow_enb();
    int f, g, last, fall;
    logic [7:0] b, rx;
    logic stop_s, e;
    logic rec [0:255];
    f = frame_len(1);
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h3C : 8'($urandom);
      g = $urandom_range(1, 16);
      last = g + 16 * f;
      tick(1'b0, 1'b1, b);
      rec[0] = tx;
      for (int c = 1; c <= last + 1; c++) begin
        e = (c >= g) && (c <= last) && (((c - g) % 16) == 0);
        tick(e, 1'b0, 8'h00);
        rec[c] = tx;
        n_tests++;
        if (c <= g || c > last) begin
          if ({tx, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL slow_idle b=%h cyc%0d: tx/busy/done=%b expected 100", b, c, {tx, busy, done});
          end
        end else if ({tx, busy, done} !== {frame_bit(b, (c - g - 1) / 16), 1'b1, 1'(c == last)}) begin
          n_fail++;
          $display("FAIL slow_frame b=%h cyc%0d: tx/busy/done=%b expected %b", b, c,
                   {tx, busy, done}, {frame_bit(b, (c - g - 1) / 16), 1'b1, 1'(c == last)});
        end
      end
      fall = -1;
      for (int c = 0; c <= last + 1; c++) if (fall < 0 && rec[c] == 1'b0) fall = c;
      rx = '0;
      stop_s = 1'b0;
      if (fall >= 0) begin
        for (int j = 0; j < 8; j++) rx[j] = rec[fall + 8 + 16 * (j + 1)];
        stop_s = rec[fall + 8 + 16 * (f - 1)];
      end
      n_tests++;
      if ({rx, stop_s} !== {b, 1'b1}) begin
        n_fail++;
        $display("FAIL slow_decode: got byte %h stop %b expected %h stop 1", rx, stop_s, b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f;
    logic [7:0] a, b;
    logic exp_tx;
    f = frame_len(1);
    for (int n = 0; n < 3; n++) begin
      a = (n == 0) ? 8'h55 : 8'($urandom);
      b = (n == 0) ? 8'hF0 : 8'($urandom);
      tick(1'b0, 1'b1, a);
      tick(1'b1, 1'b0, 8'h00);
      n_tests++;
      if (data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ready_first: ready=%b expected 0", data_ready);
      end
      for (int k = 0; k < 2 * f; k++) begin
        tick(1'b1, 1'(k == 0), b);
        exp_tx = (k < f) ? frame_bit(a, k) : frame_bit(b, k - f);
        n_tests++;
        if ({tx, busy, done, data_ready} !== {exp_tx, 1'b1, 1'(k == f - 1 || k == 2 * f - 1), 1'(k == 0 || k >= f)}) begin
          n_fail++;
          $display("FAIL b2b %h/%h cyc%0d: tx/busy/done/ready=%b expected %b", a, b, k,
                   {tx, busy, done, data_ready},
                   {exp_tx, 1'b1, 1'(k == f - 1 || k == 2 * f - 1), 1'(k == 0 || k >= f)});
        end
      end
      tick(1'b0, 1'b0, 8'h00);
      n_tests++;
      if ({tx, busy, done, data_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL b2b_end: tx/busy/done/ready=%b expected 1001", {tx, busy, done, data_ready});
      end
    end
  endtask

  task automatic test_accept_on_done();
    int f;
    logic [7:0] a, b;
    f = frame_len(1);
    a = 8'($urandom);
    b = 8'($urandom);
    tick(1'b0, 1'b1, a);
    tick(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < f; k++) begin
      tick(1'b1, 1'(k == f - 1), b);
      n_tests++;
      if ({tx, done} !== {frame_bit(a, k), 1'(k == f - 1)}) begin
        n_fail++;
        $display("FAIL acc_done_first bit%0d: tx/done=%b expected %b", k, {tx, done}, {frame_bit(a, k), 1'(k == f - 1)});
      end
    end
    tick(1'b1, 1'b0, 8'h00);
    n_tests++;
    if ({tx, busy, done, data_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL acc_done_gap: tx/busy/done/ready=%b expected 1000", {tx, busy, done, data_ready});
    end
    for (int k = 0; k < f; k++) begin
      tick(1'b1, 1'b0, 8'h00);
      n_tests++;
      if ({tx, busy, done, data_ready} !== {frame_bit(b, k), 1'b1, 1'(k == f - 1), 1'b1}) begin
        n_fail++;
        $display("FAIL acc_done_second bit%0d: tx/busy/done/ready=%b expected %b", k,
                 {tx, busy, done, data_ready}, {frame_bit(b, k), 1'b1, 1'(k == f - 1), 1'b1});
      end
    end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    int f, j;
    logic [7:0] a, b;
    f = frame_len(1);
    for (int n = 0; n < 2; n++) begin
      a = (n == 0) ? 8'h81 : 8'($urandom);
      b = (n == 0) ? 8'h42 : 8'($urandom);
      j = (n == 0) ? 3 : $urandom_range(0, 7);
      tick(1'b0, 1'b1, a);
      tick(1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b1, b);
      for (int k = 1; k <= 1 + j; k++) begin
        tick(1'b1, 1'b0, 8'h00);
        n_tests++;
        if ({tx, busy, data_ready} !== {frame_bit(a, k), 2'b10}) begin
          n_fail++;
          $display("FAIL rstmid_pre bit%0d: tx/busy/ready=%b expected %b", k, {tx, busy, data_ready}, {frame_bit(a, k), 2'b10});
        end
      end
      rst = 1'b1;
      tick(1'b1, 1'b0, 8'h00);
      n_tests++;
      if ({tx, busy, done, data_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL rstmid_after: tx/busy/done/ready=%b expected 1001", {tx, busy, done, data_ready});
      end
      rst = 1'b0;
      for (int c = 0; c < 2 * f + 4; c++) begin
        tick(1'b1, 1'b0, 8'h00);
        n_tests++;
        if ({tx, busy, done} !== 3'b100) begin
          n_fail++;
          $display("FAIL rstmid_discard cyc%0d: tx/busy/done=%b expected 100", c, {tx, busy, done});
        end
      end
    end
  endtask

  task automatic test_two_stop();
    int f;
    logic [7:0] b;
    f = frame_len(2);
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'h00 : 8'($urandom);
      tick(1'b0, 1'b1, b);
      tick(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < f; k++) begin
        tick(1'b1, 1'b0, 8'h00);
        n_tests++;
        if ({tx2, busy2, done2} !== {frame_bit(b, k), 1'b1, 1'(k == f - 1)}) begin
          n_fail++;
          $display("FAIL stop2 b=%h bit%0d: tx/busy/done=%b expected %b", b, k,
                   {tx2, busy2, done2}, {frame_bit(b, k), 1'b1, 1'(k == f - 1)});
        end
      end
      tick(1'b0, 1'b0, 8'h00);
      n_tests++;
      if ({tx2, busy2, done2, data_ready2} !== 4'b1001) begin
        n_fail++;
        $display("FAIL stop2_end b=%h: tx/busy/done/ready=%b expected 1001", b, {tx2, busy2, done2, data_ready2});
      end
    end
  endtask

  initial begin
    test_reset();
    test_enb_high();
    test_slow_enb();
    test_back_to_back();
    test_accept_on_done();
    test_reset_mid_frame();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-serial UART transmitter; the transmit-side counterpart of the team's UART receiver.
- Uses the same shared baud-tick enable (`enb`). Bit timing is owned by an external baud generator.
- Accepts parallel bytes over a valid/ready handshake into a one-entry holding buffer, so back-to-back frames go out with no idle gap.
- Serialises each byte as: start bit, data LSB-first, optional parity, stop bit(s).

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  baud tick; one-cycle pulse, once per bit period.
- data_in  input  DATA_BITS  byte to transmit.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  holding buffer empty; a byte can be accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is being shifted out (state != IDLE).
- done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`).
- Reset values: tx=1, busy=0, done=0, data_ready=1, state=IDLE, holding buffer empty, bit index=0, stop count=0.
- Reset mid-frame: tx returns to 1 on the cycle after rst is sampled. Any buffered byte is discarded. No done pulse.
- Handshake:
  - Accept occurs when data_valid && data_ready at a posedge; data_in is latched into the holding buffer.
  - data_ready = !buf_full (registered flag).
  - data_in is ignored when data_ready=0.
- State machine: IDLE, START, DATA, PARITY (only with the feature), STOP. Outside IDLE, state advances only on cycles with enb=1.
- IDLE:
  - tx=1.
  - If buf_full && enb: load shift register from buffer, clear buf_full (data_ready=1 next cycle), go to START.
  - Leaving IDLE only on a tick gives a full-length start bit.
- START: tx=0. On enb, go to DATA with index=0.
- DATA:
  - tx = shift[0].
  - On enb: shift right; index+1.
  - When index == DATA_BITS-1, go to PARITY (if enabled) else STOP.
- STOP:
  - tx=1. Lasts STOP_BITS ticks.
  - On the final tick: assert done for that single cycle.
  - Then if buf_full: reload shift register, clear buf_full, go directly to START (back-to-back, no idle bit). Otherwise go to IDLE.
- Simultaneous events:
  - Buffer load into the shifter and a new accept cannot coincide, because data_ready=0 while buf_full.
  - An accept in the same cycle as done is legal when the buffer was empty. That byte waits for the next IDLE tick.
- enb held high continuously: each bit lasts exactly one clock. This is legal and used in test.
- enb asserted during IDLE with an empty buffer: no effect.
- Latency: first start-bit edge appears 1 cycle after the first enb tick that follows an accept. Frame length = 1 + DATA_BITS (+1 parity) + STOP_BITS ticks.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - tx = even parity (XOR of all data bits), held for one tick.
  - The parity bit is computed at shift-register load time and stored.
- Undefined: DATA goes straight to STOP; no parity logic or register exists.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP, 3-bit encoding shared with the receiver).
  - UART_IDLE_LEVEL = 1'b1.
  - UART_START_LEVEL = 1'b0.
- Sub-module uart_tx_buf: the one-entry holding register with valid/ready and a load/clear strobe from the FSM.
- FSM and shifter stay in uart_tx.

Test Plan:
1. enb tied high; send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 on consecutive cycles. done pulses once on the stop cycle. busy=1 for 10 cycles.
2. enb every 16 cycles; send 0x3C -> each bit held exactly 16 cycles. Decoded by the team's receiver model as 0x3C.
3. Back-to-back: accept 0x55, then 0xF0 while busy -> data_ready drops after the second accept. Stop bit of 0x55 is followed immediately by the start bit of 0xF0 (no idle tick). Two done pulses.
4. Assert rst during DATA bit 3 of 0x81, with 0x42 buffered -> tx=1, busy=0, data_ready=1 next cycle. No done. 0x42 is never sent.
5. STOP_BITS=2, send 0x00 -> tx low for 9 ticks, high for 2 ticks. done only at the end of the second tick.
6. UART_TX_PARITY_EN defined, enb high:
   - 0xA5 -> parity bit 0 after data, frame length 11 cycles.
   - 0x07 -> parity bit 1.
